// File: rtl/branch_resolution_unit_if.sv
// Execute-side branch resolution bundle: pipeline control, fetch prediction, Execute outcome
// and resolution results. BRU_STATS_EN adds the branch/mispredict counter outputs.
interface branch_resolution_unit_if #(
    parameter int HIST_BITS = 2,
    parameter int ADDR_W    = 32
);
    logic                 stall_d_i;
    logic                 flush_d_i;
    logic                 flush_e_i;
    logic                 pc_src_pred_f_i;
    logic [ADDR_W-1:0]    pred_pc_target_f_i;
    logic [1:0]           branch_op_e_i;
    logic                 branch_taken_e_i;
    logic [ADDR_W-1:0]    pc_target_e_i;
    logic [ADDR_W-1:0]    pc_plus4_e_i;
    logic                 pc_src_res_e_o;
    logic                 target_match_o;
    logic [HIST_BITS-1:0] local_src_o;
    logic                 mispredict_e_o;
    logic [ADDR_W-1:0]    redirect_pc_e_o;
`ifdef BRU_STATS_EN
    logic [31:0]          branch_cnt_o;
    logic [31:0]          mispredict_cnt_o;
`endif

    modport master (
        output stall_d_i, flush_d_i, flush_e_i, pc_src_pred_f_i, pred_pc_target_f_i,
               branch_op_e_i, branch_taken_e_i, pc_target_e_i, pc_plus4_e_i,
        input  pc_src_res_e_o, target_match_o, local_src_o, mispredict_e_o, redirect_pc_e_o
`ifdef BRU_STATS_EN
        , input branch_cnt_o, mispredict_cnt_o
`endif
    );

    modport slave (
        input  stall_d_i, flush_d_i, flush_e_i, pc_src_pred_f_i, pred_pc_target_f_i,
               branch_op_e_i, branch_taken_e_i, pc_target_e_i, pc_plus4_e_i,
        output pc_src_res_e_o, target_match_o, local_src_o, mispredict_e_o, redirect_pc_e_o
`ifdef BRU_STATS_EN
        , output branch_cnt_o, mispredict_cnt_o
`endif
    );
endinterface

// File: rtl/branch_resolution_unit.sv
// Carries fetch predictions F->D->E, checks them against the resolved outcome, and drives the
// buffer update, global history and misprediction redirect. Optional macro: BRU_STATS_EN.
module branch_resolution_unit #(
    parameter int HIST_BITS = 2,
    parameter int ADDR_W    = 32
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    branch_resolution_unit_if.slave bus
);
    logic                 pred_d_p1;
    logic [ADDR_W-1:0]    target_d_p1;
    logic                 pred_e_p2;
    logic [ADDR_W-1:0]    target_e_p2;
    logic [HIST_BITS-1:0] ghr;
    logic                 is_branch;
    logic                 res_taken;
    logic                 target_match;
    logic                 mispredict;
    logic [ADDR_W-1:0]    redirect_pc;
    logic                 unused_op_hi;

    assign unused_op_hi = bus.branch_op_e_i[1];

    // F -> D: flush wins over stall
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pred_d_p1   <= 1'b0;
            target_d_p1 <= '0;
        end else if (bus.flush_d_i) begin
            pred_d_p1   <= 1'b0;
            target_d_p1 <= '0;
        end else if (!bus.stall_d_i) begin
            pred_d_p1   <= bus.pc_src_pred_f_i;
            target_d_p1 <= bus.pred_pc_target_f_i;
        end
    end

    // D -> E: a flush inserts a bubble carrying no prediction
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i || bus.flush_e_i) begin
            pred_e_p2   <= 1'b0;
            target_e_p2 <= '0;
        end else begin
            pred_e_p2   <= pred_d_p1;
            target_e_p2 <= target_d_p1;
        end
    end

    // Execute: resolve against the carried prediction
    assign is_branch    = bus.branch_op_e_i[0];
    assign res_taken    = is_branch & bus.branch_taken_e_i & ~reset_i;
    assign target_match = (target_e_p2 == bus.pc_target_e_i);

    always_comb begin
        mispredict  = 1'b0;
        redirect_pc = bus.pc_plus4_e_i;
        if (!reset_i) begin
            if (is_branch && bus.branch_taken_e_i) begin
                if (!pred_e_p2 || !target_match) begin
                    mispredict  = 1'b1;
                    redirect_pc = bus.pc_target_e_i;
                end
            end else if (pred_e_p2) begin
                // Predicted taken but fell through, or an aliased hit on a non-branch
                mispredict = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ghr <= '0;
        end else if (is_branch) begin
            ghr <= {ghr[HIST_BITS-2:0], res_taken};
        end
    end

    assign bus.pc_src_res_e_o  = res_taken;
    assign bus.target_match_o  = target_match;
    assign bus.local_src_o     = ghr;
    assign bus.mispredict_e_o  = mispredict;
    assign bus.redirect_pc_e_o = redirect_pc;

`ifdef BRU_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (is_branch)  branch_cnt     <= sat_inc(branch_cnt);
            if (mispredict) mispredict_cnt <= sat_inc(mispredict_cnt);
        end
    end

    assign bus.branch_cnt_o     = branch_cnt;
    assign bus.mispredict_cnt_o = mispredict_cnt;
`endif
endmodule

// File: tb/tb_branch_resolution_unit.sv
// Bench for branch_resolution_unit: fixed vector table, stall/flush/reset sequences and a
// randomized run against a behavioural model. Counter checks compile in with BRU_STATS_EN.
module tb_branch_resolution_unit;
    localparam int HB = 2;
    localparam int AW = 32;

    typedef struct {
        logic        pf;
        logic [31:0] tf;
        logic [1:0]  bop;
        logic        tk;
        logic [31:0] pct;
        logic [31:0] p4;
        logic        res;
        logic        tm;
        logic        mis;
        logic [31:0] red;
        logic [1:0]  lsrc;
    } vec_t;

    typedef struct {
        bit          p;
        logic [31:0] t;
    } pred_t;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;

    branch_resolution_unit_if #(.HIST_BITS(HB), .ADDR_W(AW)) bus ();

    branch_resolution_unit #(.HIST_BITS(HB), .ADDR_W(AW)) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic drive(input logic st, fd, fe, pf, input logic [31:0] tf, input logic [1:0] bop,
                         input logic tk, input logic [31:0] pct, p4);
        bus.stall_d_i          = st;
        bus.flush_d_i          = fd;
        bus.flush_e_i          = fe;
        bus.pc_src_pred_f_i    = pf;
        bus.pred_pc_target_f_i = tf;
        bus.branch_op_e_i      = bop;
        bus.branch_taken_e_i   = tk;
        bus.pc_target_e_i      = pct;
        bus.pc_plus4_e_i       = p4;
    endtask

    task automatic check_outs(input string tag, input logic res, tm, mis, input logic [31:0] red,
                              input logic [1:0] lsrc);
        check({tag, " res"},      64'(bus.pc_src_res_e_o),  64'(res));
        check({tag, " tmatch"},   64'(bus.target_match_o),  64'(tm));
        check({tag, " mispred"},  64'(bus.mispredict_e_o),  64'(mis));
        check({tag, " redirect"}, 64'(bus.redirect_pc_e_o), 64'(red));
        check({tag, " local"},    64'(bus.local_src_o),     64'(lsrc));
    endtask

    vec_t        tbl[12];
    pred_t       md, me, me_n;
    int          ghr_m;
    int unsigned bc_m, mc_m;
    logic        r_st, r_fd, r_fe, r_pf, r_tk, act_t, mis_e;
    logic [1:0]  r_bop;
    logic [31:0] r_tf, r_pct, r_p4, red_e;
    logic [31:0] tgts[4];

    initial begin
        tbl[0]  = '{1'b1, 32'h40, 2'b00, 1'b0, 32'h0,   32'h4,   1'b0, 1'b1, 1'b0, 32'h4,   2'b00};
        tbl[1]  = '{1'b1, 32'h40, 2'b00, 1'b0, 32'h0,   32'h8,   1'b0, 1'b1, 1'b0, 32'h8,   2'b00};
        tbl[2]  = '{1'b1, 32'h40, 2'b01, 1'b1, 32'h40,  32'h10,  1'b1, 1'b1, 1'b0, 32'h10,  2'b00};
        tbl[3]  = '{1'b0, 32'h0,  2'b01, 1'b1, 32'h80,  32'h14,  1'b1, 1'b0, 1'b1, 32'h80,  2'b01};
        tbl[4]  = '{1'b0, 32'h0,  2'b01, 1'b0, 32'h200, 32'h104, 1'b0, 1'b0, 1'b1, 32'h104, 2'b11};
        tbl[5]  = '{1'b0, 32'h0,  2'b01, 1'b0, 32'h0,   32'h108, 1'b0, 1'b1, 1'b0, 32'h108, 2'b10};
        tbl[6]  = '{1'b0, 32'h0,  2'b01, 1'b1, 32'h300, 32'h10c, 1'b1, 1'b0, 1'b1, 32'h300, 2'b00};
        tbl[7]  = '{1'b0, 32'h0,  2'b01, 1'b0, 32'h0,   32'h110, 1'b0, 1'b1, 1'b0, 32'h110, 2'b01};
        tbl[8]  = '{1'b0, 32'h0,  2'b01, 1'b1, 32'h400, 32'h114, 1'b1, 1'b0, 1'b1, 32'h400, 2'b10};
        tbl[9]  = '{1'b1, 32'h77, 2'b00, 1'b1, 32'h500, 32'h118, 1'b0, 1'b0, 1'b0, 32'h118, 2'b01};
        tbl[10] = '{1'b0, 32'h0,  2'b10, 1'b1, 32'h0,   32'h11c, 1'b0, 1'b1, 1'b0, 32'h11c, 2'b01};
        tbl[11] = '{1'b0, 32'h0,  2'b00, 1'b0, 32'h0,   32'h120, 1'b0, 1'b0, 1'b1, 32'h120, 2'b01};
        tgts[0] = 32'h40; tgts[1] = 32'h80; tgts[2] = 32'hc0; tgts[3] = 32'h100;

        // Reset state: a taken branch at the inputs must not leak through
        rst = 1'b1;
        drive(0, 0, 0, 0, 32'h0, 2'b01, 1, 32'h0, 32'h4);
        @(negedge clk); #1;
        check_outs("reset", 0, 1, 0, 32'h4, 2'b00);

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) rst = 1'b0;
            drive(0, 0, 0, tbl[i].pf, tbl[i].tf, tbl[i].bop, tbl[i].tk, tbl[i].pct, tbl[i].p4);
            #1;
            check_outs($sformatf("tbl%0d", i), tbl[i].res, tbl[i].tm, tbl[i].mis, tbl[i].red,
                       tbl[i].lsrc);
        end

        // flush_e turns a predicted-taken transfer into a bubble
        @(negedge clk); drive(0, 0, 0, 1, 32'h90, 2'b00, 0, 32'h0, 32'h200);
        @(negedge clk); drive(0, 0, 1, 0, 32'h0,  2'b00, 0, 32'h0, 32'h204);
        @(negedge clk); drive(0, 0, 0, 0, 32'h0,  2'b00, 0, 32'h90, 32'h208); #1;
        check({"flush_e mispred"}, 64'(bus.mispredict_e_o), 64'(0));
        check({"flush_e tmatch"},  64'(bus.target_match_o), 64'(0));

        // Three stall cycles hold the D prediction
        @(negedge clk); drive(0, 0, 0, 1, 32'ha0, 2'b00, 0, 32'h0, 32'h300);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); drive(1, 0, 0, 0, 32'h0, 2'b00, 0, 32'h0, 32'h300);
        end
        @(negedge clk); drive(0, 0, 0, 0, 32'h0, 2'b01, 1, 32'ha0, 32'h300); #1;
        check("stall rel mispred", 64'(bus.mispredict_e_o), 64'(0));
        check("stall rel tmatch",  64'(bus.target_match_o), 64'(1));
        @(negedge clk); drive(0, 0, 0, 0, 32'h0, 2'b01, 1, 32'ha0, 32'h304); #1;
        check("stall held mispred", 64'(bus.mispredict_e_o), 64'(0));
        @(negedge clk); drive(0, 0, 0, 0, 32'h0, 2'b00, 0, 32'h0, 32'h308); #1;
        check("stall end mispred", 64'(bus.mispredict_e_o), 64'(0));

        // flush_d beats stall_d
        @(negedge clk); drive(0, 0, 0, 1, 32'hb0, 2'b00, 0, 32'h0, 32'h400);
        @(negedge clk); drive(1, 1, 0, 1, 32'hcc, 2'b00, 0, 32'h0, 32'h400);
        @(negedge clk); drive(0, 0, 0, 0, 32'h0, 2'b01, 1, 32'hb0, 32'h400); #1;
        check("flush_d prev mispred", 64'(bus.mispredict_e_o), 64'(0));
        @(negedge clk); drive(0, 0, 0, 0, 32'h0, 2'b01, 0, 32'h0, 32'h404); #1;
        check("flush_d mispred",  64'(bus.mispredict_e_o),  64'(0));
        check("flush_d redirect", 64'(bus.redirect_pc_e_o), 64'(32'h404));

        // Five branches, two mispredicts, then a mid-cycle reset
        @(negedge clk); rst = 1'b1; drive(0, 0, 0, 0, 32'h0, 2'b00, 0, 32'h0, 32'h600);
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            drive(0, 0, 0, 0, 32'h0, 2'b01, (k >= 3), 32'h500, 32'h600); #1;
            check($sformatf("cnt seq%0d mispred", k), 64'(bus.mispredict_e_o), 64'(k >= 3));
        end
        @(negedge clk); drive(0, 0, 0, 0, 32'h0, 2'b00, 0, 32'h0, 32'h600); #1;
        check("hist NNNTT", 64'(bus.local_src_o), 64'(2'b11));
`ifdef BRU_STATS_EN
        check("branch_cnt",     64'(bus.branch_cnt_o),     64'(5));
        check("mispredict_cnt", 64'(bus.mispredict_cnt_o), 64'(2));
`endif
        @(negedge clk); drive(0, 0, 0, 0, 32'h0, 2'b01, 1, 32'h700, 32'h604); #1;
        check("pre-reset mispred", 64'(bus.mispredict_e_o), 64'(1));
        rst = 1'b1; #1;
        check_outs("async reset", 0, 0, 0, 32'h604, 2'b00);
`ifdef BRU_STATS_EN
        check("reset branch_cnt",     64'(bus.branch_cnt_o),     64'(0));
        check("reset mispredict_cnt", 64'(bus.mispredict_cnt_o), 64'(0));
`endif

        // Randomized run against the reference model
        md = '{0, 32'h0}; me = '{0, 32'h0}; ghr_m = 0; bc_m = 0; mc_m = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (i == 0) rst = 1'b0;
            r_st  = ($urandom_range(0, 4) == 0);
            r_fd  = ($urandom_range(0, 9) == 0);
            r_fe  = ($urandom_range(0, 9) == 0);
            r_pf  = 1'($urandom_range(0, 1));
            r_tf  = tgts[$urandom_range(0, 3)];
            r_bop = 2'($urandom_range(0, 3));
            r_tk  = 1'($urandom_range(0, 1));
            r_pct = tgts[$urandom_range(0, 3)];
            r_p4  = 32'($urandom_range(0, 1023)) << 2;
            drive(r_st, r_fd, r_fe, r_pf, r_tf, r_bop, r_tk, r_pct, r_p4);
            #1;
            act_t = r_bop[0] & r_tk;
            mis_e = (me.p != act_t) || (act_t && me.t != r_pct);
            red_e = (mis_e && act_t) ? r_pct : r_p4;
            check_outs($sformatf("rnd%0d", i), act_t, (me.t == r_pct), mis_e, red_e,
                       2'(ghr_m));
            if (r_bop[0]) begin
                ghr_m = ((ghr_m << 1) | int'(act_t)) & ((1 << HB) - 1);
                bc_m++;
            end
            if (mis_e) mc_m++;
            me_n = r_fe ? '{0, 32'h0} : md;
            if (r_fd)       md = '{0, 32'h0};
            else if (!r_st) md = '{r_pf, r_tf};
            me = me_n;
        end
`ifdef BRU_STATS_EN
        @(negedge clk); drive(0, 0, 0, 0, 32'h0, 2'b00, 0, 32'h0, 32'h0); #1;
        check("rnd branch_cnt",     64'(bus.branch_cnt_o),     64'(bc_m));
        check("rnd mispredict_cnt", 64'(bus.mispredict_cnt_o), 64'(mc_m));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/branch_resolution_unit.md
Name: branch_resolution_unit

Overview:
- Execute-side counterpart to the fetch-side branching buffer.
- Carries each fetch-stage prediction (taken bit and predicted target) down the F->D->E pipeline alongside its instruction.
- In Execute, compares that prediction against the resolved branch outcome and generates the buffer's update inputs (pc_src_res_e, target_match, local_src).
- Also generates the misprediction flush/redirect consumed by the PC mux and the hazard unit.

Parameters:
- HIST_BITS, 2, width of the global history register; equals the width of local_src_o.
- ADDR_W, 32, width of PC and target addresses.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous active-high reset
- stall_d_i  in  1  hold the F->D prediction register
- flush_d_i  in  1  clear the F->D prediction register
- flush_e_i  in  1  clear the D->E prediction register
- pc_src_pred_f_i  in  1  fetch-stage predicted-taken bit from the branching buffer
- pred_pc_target_f_i  in  ADDR_W  fetch-stage predicted target
- branch_op_e_i  in  2  Execute control; bit0 = control-transfer instruction present
- branch_taken_e_i  in  1  actual condition/jump outcome from the ALU and flags
- pc_target_e_i  in  ADDR_W  computed target in Execute
- pc_plus4_e_i  in  ADDR_W  fall-through address in Execute
- pc_src_res_e_o  out  1  resolved taken; drives the buffer's pc_src_res_e_i
- target_match_o  out  1  predicted target equals the computed target
- local_src_o  out  HIST_BITS  global history; selects the local predictor
- mispredict_e_o  out  1  flush/redirect request
- redirect_pc_e_o  out  ADDR_W  correct next PC when mispredict_e_o=1

Behaviour:
- Prediction pipeline (pred_d, target_d → pred_e, target_e):
  - F->D register: loads fetch inputs when stall_d_i=0; holds when stall_d_i=1.
  - flush_d_i=1 clears the F->D register to 0 and takes priority over stall.
  - D->E register: loads from D every cycle; flush_e_i=1 clears it to 0.
  - A bubble therefore carries pred_e=0.
- Combinational outputs (same cycle as the Execute inputs):
  - pc_src_res_e_o = branch_op_e_i[0] & branch_taken_e_i.
  - target_match_o = (target_e == pc_target_e_i).
- Misprediction rules:
  - branch_op_e_i[0]=1 and taken, with pred_e=0 or target_match=0: mispredict; redirect = pc_target_e_i.
  - branch_op_e_i[0]=1, not taken, pred_e=1: mispredict; redirect = pc_plus4_e_i.
  - branch_op_e_i[0]=0 and pred_e=1 (aliased BTB hit): mispredict; redirect = pc_plus4_e_i.
  - All other cases: mispredict_e_o=0 and redirect_pc_e_o = pc_plus4_e_i, a don't-care value that is still driven deterministically.
- Global history register (ghr):
  - On each rising clk_i with branch_op_e_i[0]=1: ghr <= {ghr[HIST_BITS-2:0], pc_src_res_e_o}.
  - Otherwise ghr holds.
  - local_src_o = ghr, so an update is visible one cycle after resolution.
- Reset:
  - Asynchronous; clears all prediction registers and ghr to 0.
  - Outputs during reset: mispredict_e_o=0, pc_src_res_e_o=0, local_src_o=0.
  - target_match_o = (pc_target_e_i == 0).
  - Reset mid-operation discards in-flight predictions; no redirect is issued.
- Simultaneous stall_d_i and flush_e_i: D holds, E clears (bubble).
- No multicycle paths; the block has no internal FSM beyond the registers above.

Optional Feature:
- Macro: BRU_STATS_EN.
- When defined, adds two outputs:
  - branch_cnt_o (32-bit): increments each cycle with branch_op_e_i[0]=1.
  - mispredict_cnt_o (32-bit): increments each cycle with mispredict_e_o=1.
  - Both counters saturate at 0xFFFFFFFF and clear on reset.
- When not defined: the ports and counters are absent; the remaining behaviour is identical.

Test Plan:
1. Reset then release; pc_src_pred_f=1, target_f=0x40, no stalls. Two cycles later branch_op_e=01, taken=1, pc_target_e=0x40 → pc_src_res=1, target_match=1, mispredict=0.
2. Predicted taken to 0x40; resolved taken to 0x80 → mispredict=1, redirect=0x80, target_match=0.
3. Predicted taken; resolved not-taken with pc_plus4_e=0x104 → mispredict=1, redirect=0x104. Predicted not-taken and resolved not-taken → mispredict=0.
4. Resolve the taken/not/taken sequence T,N,T on consecutive cycles with HIST_BITS=2 → local_src goes 01, 10, 01 on the cycles following each resolution. Cycles with branch_op_e=00 hold local_src.
5. Predicted taken in F, then flush_e=1 at the D->E transfer, with branch_op_e=00 → mispredict=0. Also apply stall_d=1 for 3 cycles → pred_e equals the held prediction once the stall is released.
6. BRU_STATS_EN defined: run 5 branches with 2 mispredicts → branch_cnt=5, mispredict_cnt=2. Assert reset mid-run → both counters 0 and mispredict_e_o=0 immediately, without waiting for a clock edge.
